// File: rtl/pooling_pkg.sv
// Shared parameters, derived widths and the float32 ordering key for the
// 2x2 max-pooling datapath.
package pooling_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned TOTAL_FEATURE  = 4;
  localparam int unsigned FEATURE_WIDTH  = 6;
  localparam int unsigned FEATURE_HEIGHT = 6;

  localparam int unsigned FIDX_W = $clog2(TOTAL_FEATURE);
  localparam int unsigned COL_W  = $clog2(FEATURE_WIDTH);
  localparam int unsigned ROW_W  = $clog2(FEATURE_HEIGHT);
  localparam int unsigned PAIRS  = FEATURE_WIDTH / 2;
  localparam int unsigned PAIR_W = $clog2(PAIRS);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Registered output payload toward the pooling output interface
  typedef struct packed {
    word_t             data;
    logic [FIDX_W-1:0] fidx;
    logic [ROW_W-1:0]  row;
  } pool_out_t;

  // Maps a float32 onto an unsigned key whose ordering matches numeric order,
  // with +0 above -0.
  function automatic word_t fp32_key(input word_t x);
    if (x[DATA_WIDTH-1]) begin
      return ~x;
    end
    return x | {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/pooling_fp_max.sv
// Combinational float32 maximum; operand a wins when the keys are equal.
module pooling_fp_max
  import pooling_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] max_c
);

  word_t key_a;
  word_t key_b;

  always_comb begin
    key_a = fp32_key(a);
    key_b = fp32_key(b);
    max_c = (key_b > key_a) ? b : a;
  end

endmodule

// File: rtl/pooling_max_unit.sv
// Streaming 2x2 stride-2 max-pooling over a feature-interleaved float32
// stream; one pooled word per feature per column pair on odd rows.
module pooling_max_unit
  import pooling_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [FIDX_W-1:0]     feature_idx,
  output logic [ROW_W-1:0]      feature_row,
  output logic                  frame_done
);

  logic [FIDX_W-1:0] f_cnt;
  logic [COL_W-1:0]  c_cnt;
  logic [ROW_W-1:0]  r_cnt;

  word_t pair_buf [TOTAL_FEATURE];
  word_t line_buf [TOTAL_FEATURE][PAIRS];

  logic              accept;
  logic              f_last;
  logic              c_last;
  logic              r_last;
  logic              emit;
  logic              store_line;
  logic              store_pair;
  logic [PAIR_W-1:0] pair_idx;
  word_t             pair_rd;
  word_t             line_rd;
  word_t             h_c;
  word_t             res_c;
  pool_out_t         out_q;

  // Position decode; frame_start drops the word presented alongside it
  always_comb begin
    accept     = in_valid && !frame_start;
    f_last     = (f_cnt == FIDX_W'(TOTAL_FEATURE - 1));
    c_last     = (c_cnt == COL_W'(FEATURE_WIDTH - 1));
    r_last     = (r_cnt == ROW_W'(FEATURE_HEIGHT - 1));
    pair_idx   = PAIR_W'(c_cnt >> 1);
    store_pair = accept && !c_cnt[0];
    store_line = accept && c_cnt[0] && !r_cnt[0];
    emit       = accept && c_cnt[0] && r_cnt[0];
    pair_rd    = pair_buf[f_cnt];
    line_rd    = line_buf[f_cnt][pair_idx];
  end

  pooling_fp_max u_h_max (
    .a     (pair_rd),
    .b     (data_in),
    .max_c (h_c)
  );

  pooling_fp_max u_v_max (
    .a     (line_rd),
    .b     (h_c),
    .max_c (res_c)
  );

  // Feature / column / row position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt <= '0;
      c_cnt <= '0;
      r_cnt <= '0;
    end else if (frame_start) begin
      f_cnt <= '0;
      c_cnt <= '0;
      r_cnt <= '0;
    end else if (accept) begin
      if (f_last) begin
        f_cnt <= '0;
        if (c_last) begin
          c_cnt <= '0;
          r_cnt <= r_last ? '0 : r_cnt + ROW_W'(1);
        end else begin
          c_cnt <= c_cnt + COL_W'(1);
        end
      end else begin
        f_cnt <= f_cnt + FIDX_W'(1);
      end
    end
  end

  // Horizontal stage: hold the even-column word of each feature
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TOTAL_FEATURE; i++) begin
        pair_buf[i] <= '0;
      end
    end else if (store_pair) begin
      pair_buf[f_cnt] <= data_in;
    end
  end

  // Vertical stage: even-row horizontal maxima wait here for the odd row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TOTAL_FEATURE; i++) begin
        for (int unsigned j = 0; j < PAIRS; j++) begin
          line_buf[i][j] <= '0;
        end
      end
    end else if (store_line) begin
      line_buf[f_cnt][pair_idx] <= h_c;
    end
  end

  // Output register; payload holds between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_q      <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && f_last && c_last && r_last;
      if (emit) begin
        out_q.data <= res_c;
        out_q.fidx <= f_cnt;
        out_q.row  <= r_cnt;
      end
    end
  end

  assign data_out    = out_q.data;
  assign feature_idx = out_q.fidx;
  assign feature_row = out_q.row;

endmodule
